// File: rtl/demux_deser_pkg.sv
// Shared definitions for the serial-to-parallel demux deserializer.
//   WIDTH_DEF : default assembled word width (number of demux outputs)
//   SEL_W_DEF : default write-index width
//   st_t      : FILL collects bits, HOLD presents the finished word
package demux_deser_pkg;

    localparam int unsigned WIDTH_DEF = 64;
    localparam int unsigned SEL_W_DEF = 6;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } st_t;

    // True when idx addresses the final bit of a WIDTH-bit word.
    function automatic logic is_last_idx(input int unsigned idx, input int unsigned width);
        return (idx == (width - 1));
    endfunction

endpackage : demux_deser_pkg

// File: rtl/demux1_64_dec.sv
// One-hot write-enable decoder for the 1:WIDTH demux.
// Ports:
//   sel    : write index
//   accept : a bit is being taken this cycle
//   we_c   : one-hot enable, bit sel set only while accept is high (combinational)
module demux1_64_dec
    import demux_deser_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             accept,
    output logic [WIDTH-1:0] we_c
);

    // All-zero unless a bit is accepted, so no register is touched on idle cycles.
    always_comb begin
        we_c = '0;
        if (accept) begin
            we_c[sel] = 1'b1;
        end
    end

endmodule : demux1_64_dec

// File: rtl/demux1_64_deser.sv
// Serial-to-parallel deserializer: one bit per handshake is steered through a
// 1:WIDTH demux into out_word[sel]; sel sweeps 0..WIDTH-1 and the finished word
// is presented on a valid/ready output.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   clear      : synchronous abort of the partial or held word
//   in_valid   : in_bit is valid
//   in_bit     : serial data bit, LSB first
//   in_ready   : block can take a bit (FILL)
//   sel        : current write index
//   out_valid  : out_word holds a complete word (HOLD)
//   out_ready  : consumer takes out_word
//   out_word   : assembled word
module demux1_64_deser
    import demux_deser_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    st_t              state;
    st_t              state_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             accept_c;
    logic [WIDTH-1:0] we_c;

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);

    // clear wins over an accept, so the bit offered alongside it is dropped.
    assign accept_c = in_valid & in_ready & ~clear;

    demux1_64_dec #(
        .WIDTH (WIDTH)
    ) u_dec (
        .sel    (sel),
        .accept (accept_c),
        .we_c   (we_c)
    );

    // State and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    // Next state and next index.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        if (clear) begin
            state_nxt = FILL;
            sel_nxt   = '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept_c) begin
                        if (sel == SEL_LAST) begin
                            sel_nxt   = '0;
                            state_nxt = HOLD;
                        end else begin
                            sel_nxt = sel + SEL_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt = FILL;
                    end
                end
                default: begin
                    state_nxt = FILL;
                end
            endcase
        end
    end

    // Per-bit capture: only the enabled bit loads, so in_bit is never sampled on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word <= '0;
        end else begin
            out_word <= (out_word & ~we_c) | ({WIDTH{in_bit}} & we_c);
        end
    end

endmodule : demux1_64_deser

// File: tb/tb_demux1_64_deser.sv
module tb_demux1_64_deser;
    import demux_deser_pkg::*;

    localparam int unsigned W      = 64;
    localparam int unsigned BUDGET = 200;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic [5:0]    sel;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;

    int            compared;
    int            mismatched;
    int            cyc;
    int            last_acc_cyc;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mdl_word;
    int unsigned   mdl_sel;

    demux1_64_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every consumed word is checked against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected_word: got %h, no word expected", out_word);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (out_word !== e) begin
                    mismatched++;
                    $display("FAIL sb_word: got %h, expected %h", out_word, e);
                end
            end
        end
    end

    function automatic logic mux64_1(input logic [63:0] w, input logic [5:0] s);
        return w[s];
    endfunction

    // Offer one bit and wait (bounded) until it is accepted; tracks the reference model.
    task automatic put_bit(input logic b);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        in_bit   = b;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < BUDGET);
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL put_bit_timeout: in_ready stayed %b, expected 1", in_ready);
        end else begin
            last_acc_cyc = cyc;
            mdl_word[mdl_sel] = b;
            mdl_sel = (mdl_sel == W - 1) ? 0 : mdl_sel + 1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_bit   = 1'bx;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 64; i++) put_bit(w[i]);
        in_valid = 1'b0;
        in_bit   = 1'bx;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        mdl_word = '0; mdl_sel = 0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0 || sel !== 6'd0 || out_word !== '0) begin
            mismatched++;
            $display("FAIL reset_vals: out_valid=%b sel=%0d word=%h, expected 0/0/0", out_valid, sel, out_word);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [63:0] pat;
        pat = 64'hA5A5_A5A5_F0F0_0F0F;
        out_ready = 1'b1;
        exp_q.push_back(pat);
        send_word(pat);
        compared++;
        if (out_valid !== 1'b1 || sel !== 6'd0 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_latency: out_valid=%b sel=%0d in_ready=%b, expected 1/0/0", out_valid, sel, in_ready);
        end
        compared++;
        if (out_word !== pat) begin
            mismatched++;
            $display("FAIL basic_word: got %h, expected %h", out_word, pat);
        end
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] pat;
        pat = 64'hA5A5_A5A5_F0F0_0F0F;
        out_ready = 1'b0;
        send_word(pat);
        // Bits offered while holding must be ignored.
        in_valid = 1'b1;
        in_bit   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== pat) begin
                mismatched++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b word=%h, expected 1/0/%h",
                         i, out_valid, in_ready, out_word, pat);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        exp_q.push_back(pat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sel !== 6'd0) begin
            mismatched++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b sel=%0d, expected 0/1/0", out_valid, in_ready, sel);
        end
    endtask

    task automatic test_gaps;
        logic [63:0] pat;
        pat = 64'h0123_4567_89AB_CDEF;
        out_ready = 1'b1;
        exp_q.push_back(pat);
        for (int i = 0; i < 64; i++) begin
            put_bit(pat[i]);
            if (i < 63) begin
                compared++;
                if (sel !== 6'(mdl_sel)) begin
                    mismatched++;
                    $display("FAIL gap_sel%0d: got %0d, expected %0d", i, sel, mdl_sel);
                end
                idle(2);
                compared++;
                if (sel !== 6'(mdl_sel)) begin
                    mismatched++;
                    $display("FAIL gap_hold%0d: got %0d, expected %0d", i, sel, mdl_sel);
                end
            end
        end
        idle(1);
    endtask

    task automatic test_clear;
        logic [63:0] part;
        logic [63:0] ones;
        part = 64'h0000_0000_0000_0155;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) put_bit(part[i]);
        in_valid = 1'b0;
        compared++;
        if (sel !== 6'd10) begin
            mismatched++;
            $display("FAIL clr_pre_sel: got %0d, expected 10", sel);
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        mdl_sel = 0;
        compared++;
        if (sel !== 6'd0 || in_ready !== 1'b1 || out_word !== mdl_word) begin
            mismatched++;
            $display("FAIL clr_abort: sel=%0d in_ready=%b word=%h, expected 0/1/%h", sel, in_ready, out_word, mdl_word);
        end
        // Advance one bit, then clear together with a valid bit that must be dropped.
        put_bit(~mdl_word[0]);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_bit   = ~mdl_word[1];
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        mdl_sel  = 0;
        compared++;
        if (sel !== 6'd0 || out_word !== mdl_word) begin
            mismatched++;
            $display("FAIL clr_drop: sel=%0d word=%h, expected 0/%h", sel, out_word, mdl_word);
        end
        exp_q.push_back(ones);
        send_word(ones);
        compared++;
        if (out_word !== ones) begin
            mismatched++;
            $display("FAIL clr_ones: got %h, expected %h", out_word, ones);
        end
        idle(1);
    endtask

    task automatic test_reset_in_hold;
        out_ready = 1'b0;
        send_word(64'hDEAD_BEEF_0BAD_F00D);
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_pre_hold: out_valid=%b, expected 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_word !== '0 || sel !== 6'd0) begin
            mismatched++;
            $display("FAIL rst_async: out_valid=%b word=%h sel=%0d, expected 0/0/0", out_valid, out_word, sel);
        end
        mdl_word = '0;
        mdl_sel  = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] wa;
        logic [63:0] wb;
        int          end_a;
        wa = 64'h1357_9BDF_2468_ACE0;
        wb = 64'hC3C3_0FF0_5A5A_9669;
        out_ready = 1'b1;
        exp_q.push_back(wa);
        exp_q.push_back(wb);
        // Mux in the loop: the bit fed back is the mux input word selected by sel.
        for (int i = 0; i < 64; i++) put_bit(mux64_1(wa, sel));
        end_a = last_acc_cyc;
        put_bit(mux64_1(wb, sel));
        compared++;
        if (last_acc_cyc - end_a !== 2) begin
            mismatched++;
            $display("FAIL b2b_bubble: gap %0d cycles, expected 2", last_acc_cyc - end_a);
        end
        for (int i = 1; i < 64; i++) put_bit(mux64_1(wb, sel));
        idle(2);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        last_acc_cyc = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_clear();
        test_reset_in_hold();
        test_back_to_back();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: %0d words left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_demux1_64_deser
